// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with load, clear, cascade terminal count and hex digit drivers.
// Optional build macro COUNTER_SATURATE_EN: hold at the end values instead of wrapping.
module modn_updown_counter #(
  parameter int     WIDTH  = 8,
  parameter longint MODULO = 256,
  parameter int     DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int               PAD     = 4 * DIGITS;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);
  // One extra bit so MODULO = 2**WIDTH is representable in the clip compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] count_next;
  logic [PAD-1:0]   padded;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);

  assign tc = enable & ~clear & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      if ({1'b0, load_val} >= MOD_EXT) count_next = MAX_VAL;
      else                             count_next = load_val;
    end else if (enable) begin
      if (up_dn) begin
        if (at_max) begin
`ifdef COUNTER_SATURATE_EN
          count_next = count;
`else
          count_next = '0;
`endif
        end else begin
          count_next = count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
          count_next = count;
`else
          count_next = MAX_VAL;
`endif
        end else begin
          count_next = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else          count <= count_next;
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Top digit may cover bits above WIDTH-1; those read as zero.
  if (PAD > WIDTH) begin : g_pad
    assign padded = {{(PAD-WIDTH){1'b0}}, count};
  end else begin : g_nopad
    assign padded = count[PAD-1:0];
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign hex[7*k +: 7] = seg_decode(padded[4*k +: 4]);
  end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Randomized and directed bench for modn_updown_counter against an arithmetic reference model.
module tb_modn_updown_counter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr = 1'b0, ld = 1'b0, en = 1'b0, up = 1'b0, c_en = 1'b0;
  logic [7:0] lva = '0;
  logic [3:0] lvb = '0;
  logic [5:0] lvc = '0;

  logic [7:0]  count_a;  logic tc_a;  logic [13:0] hex_a;
  logic [3:0]  count_b;  logic tc_b;  logic [6:0]  hex_b;
  logic [5:0]  count_c;  logic tc_c;  logic [13:0] hex_c;
  logic [3:0]  units, tens;  logic tc0, tc1;  logic [6:0] hex_u, hex_t;

  int n_checks = 0;
  int n_errors = 0;
  int ma = 0, mb = 0, mc = 0, mu = 0, mt = 0;
  int tc0_pulses = 0;

  always #5 clk = ~clk;

  modn_updown_counter #(.WIDTH(8), .MODULO(256), .DIGITS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clr), .enable(en), .up_dn(up), .load(ld),
    .load_val(lva), .count(count_a), .tc(tc_a), .hex(hex_a));

  modn_updown_counter #(.WIDTH(4), .MODULO(10), .DIGITS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clr), .enable(en), .up_dn(up), .load(ld),
    .load_val(lvb), .count(count_b), .tc(tc_b), .hex(hex_b));

  modn_updown_counter #(.WIDTH(6), .MODULO(50), .DIGITS(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clr), .enable(en), .up_dn(up), .load(ld),
    .load_val(lvc), .count(count_c), .tc(tc_c), .hex(hex_c));

  modn_updown_counter #(.WIDTH(4), .MODULO(10), .DIGITS(1)) dut_units (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .enable(c_en), .up_dn(1'b1), .load(1'b0),
    .load_val(4'h0), .count(units), .tc(tc0), .hex(hex_u));

  modn_updown_counter #(.WIDTH(4), .MODULO(10), .DIGITS(1)) dut_tens (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .enable(tc0), .up_dn(1'b1), .load(1'b0),
    .load_val(4'h0), .count(tens), .tc(tc1), .hex(hex_t));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nxt(int cur, int m, bit c, bit l, int lv, bit e, bit u);
    if (c) return 0;
    if (l) return (lv >= m) ? m - 1 : lv;
    if (!e) return cur;
`ifdef COUNTER_SATURATE_EN
    if (u) return (cur == m - 1) ? cur : cur + 1;
    return (cur == 0) ? 0 : cur - 1;
`else
    if (u) return (cur + 1) % m;
    return (cur + m - 1) % m;
`endif
  endfunction

  function automatic bit exp_tc(int cur, int m, bit c, bit l, bit e, bit u);
    return e && !c && !l && (u ? (cur == m - 1) : (cur == 0));
  endfunction

  function automatic logic [6:0] seg(int n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n % 16];
  endfunction

  task automatic check_all();
    check("count_a", 32'(count_a), 32'(ma));
    check("count_b", 32'(count_b), 32'(mb));
    check("count_c", 32'(count_c), 32'(mc));
    check("tc_a", 32'(tc_a), 32'(exp_tc(ma, 256, clr, ld, en, up)));
    check("tc_b", 32'(tc_b), 32'(exp_tc(mb, 10, clr, ld, en, up)));
    check("tc_c", 32'(tc_c), 32'(exp_tc(mc, 50, clr, ld, en, up)));
    check("hex_a", 32'(hex_a), 32'({seg(ma / 16), seg(ma % 16)}));
    check("hex_b", 32'(hex_b), 32'(seg(mb)));
    check("hex_c", 32'(hex_c), 32'({seg(mc / 16), seg(mc % 16)}));
    check("units", 32'(units), 32'(mu));
    check("tens", 32'(tens), 32'(mt));
    check("tc0", 32'(tc0), 32'(exp_tc(mu, 10, 1'b0, 1'b0, c_en, 1'b1)));
  endtask

  // Inputs are driven at the falling edge; checks run 1 time unit later.
  task automatic step();
    bit t0;
    #1;
    check_all();
    t0 = exp_tc(mu, 10, 1'b0, 1'b0, c_en, 1'b1);
    if (tc0 === 1'b1) tc0_pulses++;
    @(posedge clk);
    ma = nxt(ma, 256, clr, ld, int'(lva), en, up);
    mb = nxt(mb, 10,  clr, ld, int'(lvb), en, up);
    mc = nxt(mc, 50,  clr, ld, int'(lvc), en, up);
    mu = nxt(mu, 10, 1'b0, 1'b0, 0, c_en, 1'b1);
    mt = nxt(mt, 10, 1'b0, 1'b0, 0, t0, 1'b1);
    @(negedge clk);
  endtask

  task automatic drive(input bit c, input bit l, input logic [7:0] v, input bit e, input bit u);
    clr = c; ld = l; en = e; up = u;
    lva = v; lvb = v[3:0]; lvc = v[5:0];
  endtask

  task automatic reset_all();
    ma = 0; mb = 0; mc = 0; mu = 0; mt = 0;
  endtask

  initial begin
    #1;
    check("rst_count_a", 32'(count_a), 32'd0);
    check("rst_hex_a", 32'(hex_a), 32'h2040);
    check("rst_tc_a", 32'(tc_a), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // count up from zero: 0..9,0,1 on the MODULO=10 instance
    drive(0, 0, 8'h00, 1, 1);
    repeat (12) step();

    // load 1 then count down twice through zero
    drive(0, 1, 8'h01, 0, 0);
    step();
    drive(0, 0, 8'h00, 1, 0);
    repeat (2) step();
`ifndef COUNTER_SATURATE_EN
    #1;
    check("down_wrap_ff", 32'(count_a), 32'hFF);
    check("hex_ff", 32'(hex_a), 32'h070E);
`endif

    // priority: clear over load over enable; load clipping
    drive(1, 1, 8'h33, 1, 1);
    step();
    drive(0, 1, 8'h33, 0, 1);
    step();
    drive(0, 1, 8'h0C, 0, 1);
    step();
    drive(0, 1, 8'h3F, 0, 1);
    step();
    drive(0, 0, 8'h00, 0, 1);
    step();

    // at the top value, keep counting up; then from zero, count down
    drive(0, 1, 8'hFF, 0, 1);
    step();
    drive(0, 0, 8'h00, 1, 1);
    repeat (3) step();
    drive(1, 0, 8'h00, 0, 0);
    step();
    drive(0, 0, 8'h00, 1, 0);
    repeat (2) step();

    // direction change while enabled
    drive(0, 0, 8'h00, 1, 1);
    repeat (3) step();
    drive(0, 0, 8'h00, 1, 0);
    repeat (2) step();

    // two-digit decimal cascade
    drive(0, 0, 8'h00, 0, 1);
    c_en = 1'b1;
    tc0_pulses = 0;
    repeat (100) step();
    c_en = 1'b0;
`ifndef COUNTER_SATURATE_EN
    check("casc_pulses", 32'(tc0_pulses), 32'd10);
    check("casc_wrap", 32'({tens, units}), 32'h00);
`endif
    step();

    // asynchronous reset in the middle of a count
    drive(0, 1, 8'h5A, 0, 1);
    step();
    drive(0, 0, 8'h00, 1, 1);
    repeat (3) step();
    drive(0, 0, 8'h00, 1, 0);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(count_a), 32'd0);
    check("mid_rst_hex", 32'(hex_a), 32'h2040);
    check("mid_rst_tc", 32'(tc_a), 32'd1);
    @(posedge clk);
    #1;
    check("rst_hold", 32'(count_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    reset_all();
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(15) == 0), ($urandom_range(7) == 0), 8'($urandom),
            ($urandom_range(3) != 0), 1'($urandom));
      c_en = 1'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
